demux_1to4_buf: RTL
===================

# demux_1to4_buf

Registered 1-to-4 demultiplexer with valid/ready handshaking, the distribution counterpart of the 4-to-1 selector path. It accepts one data item per cycle from a single source and routes it to one of four output channels. The channel is chosen by the 2-bit select (`sel1`,`sel0`) or by an internal round-robin pointer. Each channel holds its item in a one-entry output buffer until the consumer takes it, and counts the items delivered to it.

## Interface
- `WIDTH`, 1: data width of the input and of each channel output.
- `CNT_W`, 8: width of each per-channel delivery counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d`  in  WIDTH  input data.
- `in_valid`  in  1  `d` is valid this cycle.
- `in_ready`  out  1  block can accept `d` this cycle (combinational).
- `sel0`, `sel1`  in  1 each  explicit channel select; channel index = {`sel1`,`sel0`}.
- `rr_mode`  in  1  0 = route by `sel1`/`sel0`; 1 = route by the round-robin pointer.
- `y0`..`y3`  out  WIDTH each  channel output data registers.
- `out_valid`  out  4  bit i = channel i buffer holds an undelivered item.
- `out_ready`  in  4  bit i = channel i consumer takes the item this cycle.
- `cnt0`..`cnt3`  out  CNT_W each  items accepted into channel i.
- `rr_ptr`  out  2  current round-robin pointer.

## Operation
- Target channel `t`:
  - `rr_mode`=1: `t` = `rr_ptr`.
  - `rr_mode`=0: `t` = {`sel1`,`sel0`}.
  - Both `rr_mode` and the selects are sampled combinationally every cycle.
- `in_ready` = !`out_valid[t]` || `out_ready[t]`.
  - An item can enter a full buffer in the same cycle its old item is consumed.
- Accept condition is `in_valid` && `in_ready`. On accept:
  - `y_t` <= `d`, `out_valid[t]` <= 1.
  - `cnt_t` <= `cnt_t` + 1, modulo 2^CNT_W (wraps 2^CNT_W-1 -> 0, no saturation).
  - If `rr_mode`=1, `rr_ptr` <= `rr_ptr` + 1 mod 4 (3 -> 0).
- Channel i ≠ `t` with `out_valid[i]` && `out_ready[i]`: `out_valid[i]` <= 0. `y_i` holds its last value.
- Channel `t` with consume and accept in the same cycle: `out_valid[t]` stays 1, `y_t` takes the new `d`.
- `out_ready[i]` while `out_valid[i]`=0: ignored, no state change.
- `in_valid`=0: no data or counter update. `out_valid` bits clear only on consume.
- `rr_ptr` advances only on an accept made with `rr_mode`=1.
  - Switching `rr_mode` never resets or moves `rr_ptr`. Round robin resumes where it stopped.
- Only one channel is written per cycle. No item is ever duplicated or dropped.
- Stall: `in_valid`=1 with `in_ready`=0. The item is not accepted, and the source holds `d` until an accept.

## Timing
- Reset (`rst_n`=0, asynchronous, no clock needed):
  - `y0`..`y3` = 0, `out_valid` = 4'b0000, `cnt0`..`cnt3` = 0, `rr_ptr` = 0.
  - `in_ready` = 1 as soon as `out_valid` clears.
- Reset deassertion takes effect at the first rising edge after `rst_n` rises.
- Reset mid-transfer discards all buffered items. The consumer sees `out_valid` fall immediately.
- Latency: an item accepted at edge k is visible on `y_t`, with `out_valid[t]`=1, after edge k. That is 1 cycle.
- `in_ready` depends combinationally on `out_valid`, `out_ready`, `rr_mode`, `sel0`, `sel1` and `rr_ptr`.
  - `in_ready` does not depend on `in_valid`.
- Throughput: 1 item/cycle when the consumers keep up. Round robin with all `out_ready`=1 sustains 4 items in 4 cycles.
- All other outputs are registered.

## Test plan
- Explicit routing: `rr_mode`=0, all `out_ready`=1, `WIDTH`=1. Send `d`=1 with {`sel1`,`sel0`}=2'b10, then `d`=1 with 2'b01.
  - `y2`=1 and `out_valid`=4'b0100 after edge 1.
  - `y1`=1 and `out_valid`=4'b0010 after edge 2.
  - `cnt2`=1, `cnt1`=1.
- Backpressure: `rr_mode`=0, select 2'b11, `out_ready[3]`=0, `in_valid`=1 for 3 cycles with `d`=1,0,0.
  - `y3`=1 is held; `in_ready`=0 from cycle 2 on; `cnt3`=1.
  - Raise `out_ready[3]`: the pending `d`=0 is accepted that cycle and `cnt3`=2.
- Round robin: `rr_mode`=1, all ready, 6 accepts.
  - Channels 0,1,2,3,0,1 are hit; `rr_ptr`=2; `cnt0`=`cnt1`=2, `cnt2`=`cnt3`=1.
  - Switch to `rr_mode`=0 for 1 accept, then back to 1: the next accept goes to channel 2.
- Counter wrap: `CNT_W`=2, 5 accepts to channel 0 -> `cnt0`=1.
- Async reset: assert `rst_n`=0 between edges while `out_valid`=4'b1010.
  - All outputs reach their reset values before the next edge.
  - The first accept after release goes to channel 0 in round-robin mode.

Source files
------------

// File: rtl/demux_1to4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready handshaking, one-entry output buffer and
// delivery counter per channel; routing by explicit select or by a round-robin pointer.
module demux_1to4_buf #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             rr_mode,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [1:0]       rr_ptr
);

    logic [WIDTH-1:0] y_q   [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [3:0]       valid_q;
    logic [1:0]       ptr_q;
    logic [1:0]       tgt;
    logic             accept;

    always_comb begin
        tgt      = rr_mode ? ptr_q : {sel1, sel0};
        // A full buffer can take a new item in the same cycle its old one is consumed.
        in_ready = !valid_q[tgt] || out_ready[tgt];
        accept   = in_valid && in_ready;
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic hit;
        assign hit = accept && (tgt == 2'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q[i]     <= '0;
                cnt_q[i]   <= '0;
                valid_q[i] <= 1'b0;
            end else if (hit) begin
                y_q[i]     <= d;
                cnt_q[i]   <= cnt_q[i] + 1'b1;
                valid_q[i] <= 1'b1;
            end else if (valid_q[i] && out_ready[i]) begin
                valid_q[i] <= 1'b0;
            end
        end
    end

    // Pointer moves only on round-robin accepts, so toggling rr_mode resumes where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (accept && rr_mode) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];
    assign cnt3      = cnt_q[3];
    assign out_valid = valid_q;
    assign rr_ptr    = ptr_q;

endmodule
